// File: rtl/audio_clk_gen_pkg.sv
// Shared types and constants for the multi-channel NCO audio clock generator.
package audio_clk_gen_pkg;

  typedef enum logic [1:0] {
    RST_HOLD = 2'd0,
    SETTLE   = 2'd1,
    LOCKED   = 2'd2
  } state_t;

  localparam logic [31:0] AUDIO_INC_12M_50M = 32'h3D70A3D7;

  // Increment for f_out from f_ref with an acc_w-bit accumulator (truncating).
  function automatic logic [63:0] inc_from_ratio(input longint unsigned f_out,
                                                 input longint unsigned f_ref,
                                                 input int unsigned     acc_w);
    return (f_out << acc_w) / f_ref;
  endfunction

endpackage

// File: rtl/audio_clk_gen_nco.sv
// One phase-accumulator channel: increment register, accumulator, registered MSB and rise tick.
module audio_clk_gen_nco #(
  parameter int              ACC_W   = 32,
  parameter logic [ACC_W-1:0] INC_RST = '0
) (
  input  logic             refclk,
  input  logic             rst,
  input  logic             load,
  input  logic [ACC_W-1:0] load_inc,
  input  logic             clr,
  output logic             outclk,
  output logic             tick
);

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] inc;
  logic [ACC_W-1:0] acc_nxt;

  assign acc_nxt = acc + inc;

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      acc    <= '0;
      inc    <= INC_RST;
      outclk <= 1'b0;
      tick   <= 1'b0;
    end else begin
      if (load) inc <= load_inc;
      // A zero increment parks the channel at phase 0 with a quiet output.
      if (clr || (inc == '0)) begin
        acc    <= '0;
        outclk <= 1'b0;
        tick   <= 1'b0;
      end else begin
        acc    <= acc_nxt;
        outclk <= acc_nxt[ACC_W-1];
        tick   <= acc_nxt[ACC_W-1] & ~outclk;
      end
    end
  end

endmodule

// File: rtl/audio_clk_gen.sv
// N_CLK-channel NCO clock generator with settle/lock FSM and runtime retune port.
// Optional AUDIO_CLK_GEN_SYNC_RESTART_EN: a valid retune re-aligns every channel's phase.
module audio_clk_gen
  import audio_clk_gen_pkg::*;
#(
  parameter int N_CLK       = 3,
  parameter int ACC_W       = 32,
  parameter int LOCK_CYCLES = 1024,
  parameter logic [N_CLK*ACC_W-1:0] INC_INIT =
    (N_CLK*ACC_W)'(AUDIO_INC_12M_50M >> (32 - ACC_W)),
  localparam int SEL_W = (N_CLK > 1) ? $clog2(N_CLK) : 1
) (
  input  logic             refclk,
  input  logic             rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [SEL_W-1:0] cfg_sel,
  input  logic [ACC_W-1:0] cfg_inc,
  output logic [N_CLK-1:0] outclk,
  output logic [N_CLK-1:0] tick,
  output logic             locked
);

  localparam int               CNT_W    = $clog2(LOCK_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LOCK_CYCLES - 1);
  localparam logic [SEL_W:0]   N_SEL    = (SEL_W+1)'(N_CLK);

  state_t           state;
  logic [CNT_W-1:0] settle_cnt;
  logic             sel_ok;
  logic             wr_ok;
  logic             sync_clr;

  assign sel_ok = ({1'b0, cfg_sel} < N_SEL);
  assign wr_ok  = cfg_valid & cfg_ready & sel_ok;

  // Settle timer is a down-counter; an accepted write always wins over terminal count.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state      <= RST_HOLD;
      settle_cnt <= CNT_LOAD;
      cfg_ready  <= 1'b0;
      locked     <= 1'b0;
    end else begin
      case (state)
        RST_HOLD: begin
          state      <= SETTLE;
          settle_cnt <= CNT_LOAD;
          cfg_ready  <= 1'b1;
        end
        SETTLE: begin
          if (wr_ok) begin
            settle_cnt <= CNT_LOAD;
          end else if (settle_cnt == '0) begin
            state  <= LOCKED;
            locked <= 1'b1;
          end else begin
            settle_cnt <= settle_cnt - 1'b1;
          end
        end
        LOCKED: begin
          if (wr_ok) begin
            state      <= SETTLE;
            settle_cnt <= CNT_LOAD;
            locked     <= 1'b0;
          end
        end
        default: begin
          state     <= RST_HOLD;
          cfg_ready <= 1'b0;
          locked    <= 1'b0;
        end
      endcase
    end
  end

`ifdef AUDIO_CLK_GEN_SYNC_RESTART_EN
  // Delayed one cycle so the clear lands on the same edge the new increment takes effect.
  logic restart_q;

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) restart_q <= 1'b0;
    else     restart_q <= wr_ok;
  end

  assign sync_clr = restart_q;
`else
  assign sync_clr = 1'b0;
`endif

  for (genvar i = 0; i < N_CLK; i++) begin : g_ch
    audio_clk_gen_nco #(
      .ACC_W   (ACC_W),
      .INC_RST (INC_INIT[i*ACC_W +: ACC_W])
    ) u_nco (
      .refclk   (refclk),
      .rst      (rst),
      .load     (wr_ok && (cfg_sel == SEL_W'(i))),
      .load_inc (cfg_inc),
      .clr      (sync_clr),
      .outclk   (outclk[i]),
      .tick     (tick[i])
    );
  end

endmodule

// File: tb/tb_audio_clk_gen.sv
// Directed bench for audio_clk_gen: reset/lock table, retune, bad select, stop, ratio count, async reset.
module tb_audio_clk_gen;
  import audio_clk_gen_pkg::*;

  logic        refclk = 1'b0;
  logic        rst    = 1'b1;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [1:0]  cfg_sel = '0;
  logic [31:0] cfg_inc = '0;
  logic [2:0]  outclk;
  logic [2:0]  tick;
  logic        locked;

  int edge_n;
  int n_checks = 0;
  int n_fail   = 0;

  audio_clk_gen #(
    .N_CLK       (3),
    .ACC_W       (32),
    .LOCK_CYCLES (16),
    .INC_INIT    ({32'h0, 32'h0, 32'h4000_0000})
  ) dut (
    .refclk    (refclk),
    .rst       (rst),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_sel   (cfg_sel),
    .cfg_inc   (cfg_inc),
    .outclk    (outclk),
    .tick      (tick),
    .locked    (locked)
  );

  always #5 refclk = ~refclk;

  always @(posedge refclk or posedge rst) begin
    if (rst) edge_n <= 0;
    else     edge_n <= edge_n + 1;
  end

  typedef struct {
    int   k;
    logic o0;
    logic t0;
    logic rdy;
    logic lck;
  } vec_t;

  vec_t vecs [15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at edge %0d: got %0h expected %0h", name, edge_n, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge refclk);
      #1;
    end
  endtask

  task automatic do_write(input logic [1:0] sel, input logic [31:0] inc, output int n_edge);
    @(negedge refclk);
    cfg_valid = 1'b1;
    cfg_sel   = sel;
    cfg_inc   = inc;
    @(posedge refclk);
    #1;
    cfg_valid = 1'b0;
    n_edge    = edge_n;
  endtask

  task automatic wait_lock();
    int n = 0;
    while (!locked && n < 40) begin
      step(1);
      n++;
    end
    chk("wait_lock", 32'(locked), 32'd1);
  endtask

  // Channel at inc 0x40000000 whose accumulator was 0 at edge 'base'.
  function automatic logic exp_o(input int e, input int base);
    int d = e - base;
    return (d >= 0) && ((d % 4) >= 2);
  endfunction

  function automatic logic exp_t(input int e, input int base);
    int d = e - base;
    return (d >= 0) && ((d % 4) == 2);
  endfunction

  initial begin
    int n, m, ph0, ph1, cnt_t, cnt_hi;
    logic eo1;

    vecs = '{
      '{0,  1'b0, 1'b0, 1'b0, 1'b0},
      '{1,  1'b0, 1'b0, 1'b1, 1'b0},
      '{2,  1'b1, 1'b1, 1'b1, 1'b0},
      '{3,  1'b1, 1'b0, 1'b1, 1'b0},
      '{4,  1'b0, 1'b0, 1'b1, 1'b0},
      '{5,  1'b0, 1'b0, 1'b1, 1'b0},
      '{6,  1'b1, 1'b1, 1'b1, 1'b0},
      '{7,  1'b1, 1'b0, 1'b1, 1'b0},
      '{8,  1'b0, 1'b0, 1'b1, 1'b0},
      '{10, 1'b1, 1'b1, 1'b1, 1'b0},
      '{15, 1'b1, 1'b0, 1'b1, 1'b0},
      '{16, 1'b0, 1'b0, 1'b1, 1'b0},
      '{17, 1'b0, 1'b0, 1'b1, 1'b1},
      '{18, 1'b1, 1'b1, 1'b1, 1'b1},
      '{19, 1'b1, 1'b0, 1'b1, 1'b1}
    };

    repeat (3) @(posedge refclk);
    @(negedge refclk);
    rst = 1'b0;
    #1;

    // Reset release, period-4 channel 0, lock at edge 17.
    foreach (vecs[i]) begin
      while (edge_n < vecs[i].k) step(1);
      chk("tbl_outclk", 32'(outclk), {29'd0, 2'b00, vecs[i].o0});
      chk("tbl_tick",   32'(tick),   {29'd0, 2'b00, vecs[i].t0});
      chk("tbl_ready",  32'(cfg_ready), 32'(vecs[i].rdy));
      chk("tbl_locked", 32'(locked),    32'(vecs[i].lck));
    end
    ph0 = 0;

    // Retune ch1 to toggle every cycle; ch0 phase continuity, relock after 16.
    do_write(2'd1, 32'h8000_0000, n);
    chk("lock_drop", 32'(locked), 32'd0);
`ifdef AUDIO_CLK_GEN_SYNC_RESTART_EN
    ph0 = n + 1;
`endif
    for (int j = 1; j <= 16; j++) begin
      step(1);
`ifdef AUDIO_CLK_GEN_SYNC_RESTART_EN
      eo1 = (j % 2 == 0);
`else
      eo1 = (j % 2 == 1);
`endif
      chk("ch1_toggle", 32'(outclk[1]), 32'(eo1));
      chk("ch0_phase",  32'(outclk[0]), 32'(exp_o(edge_n, ph0)));
      chk("relock",     32'(locked),    32'(j >= 16));
    end

    // Out-of-range select: handshake only, nothing changes.
    @(negedge refclk);
    chk("sel3_ready", 32'(cfg_ready), 32'd1);
    do_write(2'd3, 32'h1234_5678, n);
    chk("sel3_locked", 32'(locked), 32'd1);
    cnt_t = 0;
    for (int j = 0; j < 20; j++) begin
      step(1);
      if (tick[1]) cnt_t++;
      chk("sel3_locked_hold", 32'(locked),    32'd1);
      chk("sel3_ch0",         32'(outclk[0]), 32'(exp_o(edge_n, ph0)));
      chk("sel3_ch2",         32'(outclk[2]), 32'd0);
    end
    chk("sel3_ch1_ticks", 32'(cnt_t), 32'd10);

    // Zero increment stops ch1.
    do_write(2'd1, 32'h0, n);
`ifdef AUDIO_CLK_GEN_SYNC_RESTART_EN
    ph0 = n + 1;
`endif
    for (int j = 0; j < 6; j++) begin
      step(1);
      chk("stop_outclk1", 32'(outclk[1]), 32'd0);
      chk("stop_tick1",   32'(tick[1]),   32'd0);
    end
    wait_lock();

    // 12 MHz from 50 MHz: 599..600 ticks in 2500 cycles, idle channels quiet.
    do_write(2'd0, 32'(inc_from_ratio(64'd12_000_000, 64'd50_000_000, 32)), n);
    step(2);
    cnt_t  = 0;
    cnt_hi = 0;
    for (int j = 0; j < 2500; j++) begin
      step(1);
      if (tick[0]) cnt_t++;
      if (outclk[2:1] != 2'b00) cnt_hi++;
    end
    if (cnt_t < 599 || cnt_t > 600) begin
      n_checks++;
      n_fail++;
      $display("FAIL ratio_ticks: got %0d expected 599..600", cnt_t);
    end else begin
      n_checks++;
    end
    chk("idle_ch_high", 32'(cnt_hi), 32'd0);

    // Park ch0 at phase 0, restart it at 0x40000000, then bring ch1 in at the same rate.
    do_write(2'd0, 32'h0, n);
    do_write(2'd0, 32'h4000_0000, n);
`ifdef AUDIO_CLK_GEN_SYNC_RESTART_EN
    ph0 = n + 1;
`else
    ph0 = n;
`endif
    wait_lock();
    do_write(2'd1, 32'h4000_0000, m);
`ifdef AUDIO_CLK_GEN_SYNC_RESTART_EN
    ph0 = m + 1;
    ph1 = m + 1;
`else
    ph1 = m;
`endif
    for (int j = 1; j <= 12; j++) begin
      step(1);
      chk("align_o0", 32'(outclk[0]), 32'(exp_o(edge_n, ph0)));
      chk("align_o1", 32'(outclk[1]), 32'(exp_o(edge_n, ph1)));
      chk("align_t0", 32'(tick[0]),   32'(exp_t(edge_n, ph0)));
      chk("align_t1", 32'(tick[1]),   32'(exp_t(edge_n, ph1)));
    end
    wait_lock();

    // Async reset mid-settle, 5 cycles after a write; increments revert.
    do_write(2'd2, 32'h4000_0000, n);
    step(5);
    #3;
    rst = 1'b1;
    #1;
    chk("rst_outclk", 32'(outclk),    32'd0);
    chk("rst_tick",   32'(tick),      32'd0);
    chk("rst_locked", 32'(locked),    32'd0);
    chk("rst_ready",  32'(cfg_ready), 32'd0);
    repeat (2) @(posedge refclk);
    @(negedge refclk);
    rst = 1'b0;
    #1;
    for (int j = 1; j <= 8; j++) begin
      step(1);
      chk("post_rst_o0",   32'(outclk[0]), 32'(exp_o(edge_n, 0)));
      chk("post_rst_o21",  32'(outclk[2:1]), 32'd0);
      chk("post_rst_lock", 32'(locked),    32'd0);
      chk("post_rst_rdy",  32'(cfg_ready), 32'd1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/audio_clk_gen.md
# audio_clk_gen

Parametrised multi-channel numerically-controlled clock generator for the audio player. Replaces the single fixed-ratio PLL output with N_CLK independent phase-accumulator channels, each producing a square-wave clock and a one-cycle rising-edge tick, all in the `refclk` domain. Channels are retunable at runtime through a valid/ready config port. A settle counter drives `locked`, so downstream codec/I2S logic gates on it exactly as it did on PLL lock.

## Interface
- `N_CLK`, 3, number of output channels (1..8)
- `ACC_W`, 32, phase accumulator / increment width (16..32)
- `LOCK_CYCLES`, 1024, cycles in SETTLE before `locked` asserts (≥2)
- `INC_INIT`, {N_CLK{32'h0}} with channel 0 = 32'h3D70A3D7 (12 MHz from 50 MHz), packed reset increments, channel i at bits [i*ACC_W +: ACC_W]

- `refclk`  in  1  system clock
- `rst`  in  1  asynchronous reset, active high
- `cfg_valid`  in  1  config request
- `cfg_ready`  out  1  config accept
- `cfg_sel`  in  $clog2(N_CLK) (min 1)  channel to retune
- `cfg_inc`  in  ACC_W  new increment; 0 stops the channel
- `outclk`  out  N_CLK  per-channel square wave (accumulator MSB, registered)
- `tick`  out  N_CLK  one-cycle pulse on each `outclk` rising edge
- `locked`  out  1  all channels stable for LOCK_CYCLES

## Operation
- Per channel, every cycle: `acc <= acc + inc`, mod 2^ACC_W. `outclk[i] <= next acc MSB`. `tick[i]` is high when `outclk[i]` goes 0→1.
- Output frequency is f_refclk·inc/2^ACC_W. `inc` ≥ 2^(ACC_W-1) is legal but aliases. 0x80000000 gives a toggle every cycle.
- `inc == 0`: acc is forced to 0, and `outclk`/`tick` are held 0.
- FSM states:
  - RST_HOLD (reset state) → SETTLE after one cycle.
  - SETTLE: counter counts 0..LOCK_CYCLES-1, then → LOCKED.
  - LOCKED: stays until an accepted config write, then → SETTLE with the counter cleared.
- `cfg_ready` = 1 in SETTLE and LOCKED, 0 in RST_HOLD.
- A write is accepted when `cfg_valid && cfg_ready`. It loads `inc[cfg_sel]`.
- `cfg_sel ≥ N_CLK`: the handshake still completes, but nothing is written and no relock occurs.
- An accepted write during SETTLE restarts the settle counter.
- Writes to other channels leave their accumulators untouched. Phase is continuous unless the macro below is defined.
- `locked` = (state == LOCKED), registered.

## Timing
- Reset values:
  - acc = 0, inc = INC_INIT
  - outclk = 0, tick = 0
  - locked = 0, cfg_ready = 0
  - state = RST_HOLD
- `rst` overrides everything, asynchronously, at any point including mid-settle or mid-write.
- Write accepted at edge N: the new inc is first summed at edge N+1, and `locked` is 0 after edge N+1.
- First edge after reset release: `cfg_ready` rises. `locked` rises LOCK_CYCLES+1 edges after reset release.
- `tick` is coincident with the `outclk` rising edge, i.e. the same registered cycle, zero added latency.
- If `cfg_valid` is asserted in the same cycle the settle counter reaches terminal, the write wins: the block stays in SETTLE and the counter restarts.

## Configuration
- `AUDIO_CLK_GEN_SYNC_RESTART_EN`
  - Defined: every accepted write with `cfg_sel < N_CLK` clears all N_CLK accumulators (and `outclk`) at edge N+1, so all channels restart phase-aligned. Use case: MCLK/BCLK/LRCLK alignment.
  - Undefined: only the increment changes, and every channel's phase is continuous.

## Structure
- `audio_clk_gen_pkg`: FSM state enum (RST_HOLD, SETTLE, LOCKED), `AUDIO_INC_12M_50M` = 32'h3D70A3D7, and a width-generic inc-from-ratio constant function.
- Sub-module `audio_clk_gen_nco`: one accumulator + MSB register + tick detect, with an inc load and a sync-clear input. The top instantiates it N_CLK times via generate. The FSM, settle counter and config decode live in the top.

## Test plan
- Reset, LOCK_CYCLES=16, inc0=0x40000000: `cfg_ready` is 1 at edge 1. `outclk[0]` runs a period-4 pattern, 2 high / 2 low. `tick[0]` fires every 4th cycle. `locked` rises at edge 17.
- Defaults over 2500 cycles: channel 0 yields 599–600 ticks. Channels 1–2 (inc 0) have `outclk` stuck at 0.
- While locked, write sel=1, inc=0x80000000: `locked` drops the next cycle. `outclk[1]` toggles every cycle. `locked` returns after 16 cycles. Channel 0 phase is unchanged when the macro is off.
- Write sel=3 with N_CLK=3: `cfg_ready`/handshake completes, no inc change, and `locked` stays 1.
- Assert `rst` mid-settle, 5 cycles after a write: all outputs go to 0 immediately, and inc reverts to INC_INIT.
- Macro on, two channels at 0x40000000 with different phase, then write ch1: after the write both `outclk` are 0 at N+1 and their `tick` pulses coincide thereafter.
